// File: rtl/mem_ctrl.sv
// Load/store unit between the M stage and a single-port word memory with ack handshake.
// Handles lane selection, byte enables, load extension, alignment faults and bus timeout.
module mem_ctrl #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [2:0]  op_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        stall_o,
  output logic [31:0] rdata_o,
  output logic        done_o,
  output logic        adel_o,
  output logic        ades_o,
  output logic        berr_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i
);

  localparam int unsigned CntW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {StIdle, StAccess, StDone, StFault, StBusErr} state_e;

  state_e      state_q;
  logic [CntW-1:0] cnt_q;
  logic [2:0]  op_q;
  logic [1:0]  off_q;
  logic [31:0] rdata_q;
  logic        done_q, adel_q, ades_q, berr_q;
  logic        mem_req_q, mem_we_q;
  logic [3:0]  mem_be_q;
  logic [31:0] mem_addr_q, mem_wdata_q;

  logic [2:0]  op_n;
  logic        misalign;
  logic [3:0]  be_n;
  logic [31:0] wdata_n;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] load_ext;

  // Request decode; reserved op codes 5-7 behave as word accesses.
  always_comb begin
    op_n     = (op_i > 3'd4) ? 3'd0 : op_i;
    misalign = ((op_n == 3'd0) && (addr_i[1:0] != 2'b00)) ||
               (((op_n == 3'd3) || (op_n == 3'd4)) && addr_i[0]);
    be_n     = 4'b1111;
    wdata_n  = 32'h0;
    if (we_i) begin
      case (op_n)
        3'd1, 3'd2: begin
          be_n    = 4'b0001 << addr_i[1:0];
          wdata_n = {4{wdata_i[7:0]}};
        end
        3'd3, 3'd4: begin
          be_n    = addr_i[1] ? 4'b1100 : 4'b0011;
          wdata_n = {2{wdata_i[15:0]}};
        end
        default: begin
          be_n    = 4'b1111;
          wdata_n = wdata_i;
        end
      endcase
    end
  end

  always_comb begin
    case (off_q)
      2'd0:    lane_b = mem_rdata_i[7:0];
      2'd1:    lane_b = mem_rdata_i[15:8];
      2'd2:    lane_b = mem_rdata_i[23:16];
      default: lane_b = mem_rdata_i[31:24];
    endcase
    lane_h = off_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
    case (op_q)
      3'd1:    load_ext = {24'h0, lane_b};
      3'd2:    load_ext = {{24{lane_b[7]}}, lane_b};
      3'd3:    load_ext = {16'h0, lane_h};
      3'd4:    load_ext = {{16{lane_h[15]}}, lane_h};
      default: load_ext = mem_rdata_i;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      op_q        <= 3'd0;
      off_q       <= 2'd0;
      rdata_q     <= 32'h0;
      done_q      <= 1'b0;
      adel_q      <= 1'b0;
      ades_q      <= 1'b0;
      berr_q      <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= 4'h0;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
    end else begin
      done_q <= 1'b0;
      adel_q <= 1'b0;
      ades_q <= 1'b0;
      berr_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (req_i) begin
            if (misalign) begin
              state_q <= StFault;
              adel_q  <= ~we_i;
              ades_q  <= we_i;
            end else begin
              state_q     <= StAccess;
              cnt_q       <= '0;
              op_q        <= op_n;
              off_q       <= addr_i[1:0];
              mem_req_q   <= 1'b1;
              mem_we_q    <= we_i;
              mem_be_q    <= be_n;
              mem_addr_q  <= {addr_i[31:2], 2'b00};
              mem_wdata_q <= wdata_n;
            end
          end
        end
        StAccess: begin
          // An ack arriving on the final allowed cycle still completes normally.
          if (mem_ack_i) begin
            state_q   <= StDone;
            done_q    <= 1'b1;
            mem_req_q <= 1'b0;
            if (!mem_we_q) rdata_q <= load_ext;
          end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
            state_q   <= StBusErr;
            berr_q    <= 1'b1;
            mem_req_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        // DONE ignores req: it still belongs to the instruction just completed.
        StDone, StFault, StBusErr: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign stall_o     = ((state_q == StIdle) && req_i) || (state_q == StAccess);
  assign rdata_o     = rdata_q;
  assign done_o      = done_q;
  assign adel_o      = adel_q;
  assign ades_o      = ades_q;
  assign berr_o      = berr_q;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_be_o    = mem_be_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: table of single-cycle-ack transactions and faults,
// plus hand sequences for timeout, late ack, stray ack and mid-access reset.
module tb_mem_ctrl;

  logic        clk, rst_n;
  logic        req, we;
  logic [2:0]  op;
  logic [31:0] addr, wdata;
  logic        stall, done, adel, ades, berr;
  logic [31:0] rdata;
  logic        mem_req, mem_we, mem_ack;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  mem_ctrl #(.TIMEOUT(15)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_i       (req),
    .we_i        (we),
    .op_i        (op),
    .addr_i      (addr),
    .wdata_i     (wdata),
    .stall_o     (stall),
    .rdata_o     (rdata),
    .done_o      (done),
    .adel_o      (adel),
    .ades_o      (ades),
    .berr_o      (berr),
    .mem_req_o   (mem_req),
    .mem_we_o    (mem_we),
    .mem_be_o    (mem_be),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_ack_i   (mem_ack),
    .mem_rdata_i (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // fault: 0 none, 1 adel, 2 ades
  typedef struct {
    logic        we;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mrdata;
    logic [3:0]  be;
    logic [31:0] mwdata;
    logic [31:0] rdata;
    logic [1:0]  fault;
  } vec_t;

  localparam int NV = 13;
  vec_t vec [NV];

  task automatic start_req(input logic w, input logic [2:0] o, input logic [31:0] a,
                           input logic [31:0] d);
    @(negedge clk);
    req = 1'b1; we = w; op = o; addr = a; wdata = d; mem_ack = 1'b0;
    #1;
  endtask

  initial begin
    vec[0]  = '{1'b0, 3'd2, 32'h1000_0002, 32'h0,         32'h12AB_3456, 4'b1111, 32'h0,         32'hFFFF_FFAB, 2'd0};
    vec[1]  = '{1'b1, 3'd3, 32'h1000_0002, 32'h0000_BEEF, 32'h0,         4'b1100, 32'hBEEF_BEEF, 32'hFFFF_FFAB, 2'd0};
    vec[2]  = '{1'b0, 3'd0, 32'h1000_0004, 32'h0,         32'hDEAD_BEEF, 4'b1111, 32'h0,         32'hDEAD_BEEF, 2'd0};
    vec[3]  = '{1'b0, 3'd1, 32'h1000_0001, 32'h0,         32'h1122_8033, 4'b1111, 32'h0,         32'h0000_0080, 2'd0};
    vec[4]  = '{1'b0, 3'd3, 32'h1000_0002, 32'h0,         32'h8001_FFFF, 4'b1111, 32'h0,         32'h0000_8001, 2'd0};
    vec[5]  = '{1'b0, 3'd4, 32'h1000_0000, 32'h0,         32'h1234_F00D, 4'b1111, 32'h0,         32'hFFFF_F00D, 2'd0};
    vec[6]  = '{1'b1, 3'd2, 32'h1000_0003, 32'h1234_56A5, 32'h0,         4'b1000, 32'hA5A5_A5A5, 32'hFFFF_F00D, 2'd0};
    vec[7]  = '{1'b1, 3'd0, 32'h1000_0008, 32'hCAFE_F00D, 32'h0,         4'b1111, 32'hCAFE_F00D, 32'hFFFF_F00D, 2'd0};
    vec[8]  = '{1'b0, 3'd7, 32'h1000_000C, 32'h0,         32'h0102_0304, 4'b1111, 32'h0,         32'h0102_0304, 2'd0};
    vec[9]  = '{1'b0, 3'd2, 32'h1000_0003, 32'h0,         32'h7F00_0000, 4'b1111, 32'h0,         32'h0000_007F, 2'd0};
    vec[10] = '{1'b0, 3'd0, 32'h1000_0001, 32'h0,         32'h0,         4'b0000, 32'h0,         32'h0000_007F, 2'd1};
    vec[11] = '{1'b1, 3'd3, 32'h1000_0003, 32'h0000_1234, 32'h0,         4'b0000, 32'h0,         32'h0000_007F, 2'd2};
    vec[12] = '{1'b0, 3'd4, 32'h1000_0001, 32'h0,         32'h0,         4'b0000, 32'h0,         32'h0000_007F, 2'd1};

    rst_n = 1'b0; req = 1'b0; we = 1'b0; op = 3'd0; addr = 32'h0; wdata = 32'h0;
    mem_ack = 1'b0; mem_rdata = 32'h0;
    @(negedge clk); @(negedge clk); #1;
    check("rst_rdata", rdata, 32'h0);
    check("rst_mem_req", {31'h0, mem_req}, 32'h0);
    check("rst_mem_be", {28'h0, mem_be}, 32'h0);
    check("rst_stall", {31'h0, stall}, 32'h0);
    check("rst_done", {31'h0, done}, 32'h0);
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      start_req(vec[i].we, vec[i].op, vec[i].addr, vec[i].wdata);
      check($sformatf("v%0d_stall_req", i), {31'h0, stall}, 32'h1);
      check($sformatf("v%0d_mreq_idle", i), {31'h0, mem_req}, 32'h0);
      if (vec[i].fault == 2'd0) begin
        @(negedge clk); mem_ack = 1'b1; mem_rdata = vec[i].mrdata; #1;
        check($sformatf("v%0d_mem_req", i), {31'h0, mem_req}, 32'h1);
        check($sformatf("v%0d_mem_we", i), {31'h0, mem_we}, {31'h0, vec[i].we});
        check($sformatf("v%0d_mem_be", i), {28'h0, mem_be}, {28'h0, vec[i].be});
        check($sformatf("v%0d_mem_wdata", i), mem_wdata, vec[i].mwdata);
        check($sformatf("v%0d_mem_addr", i), mem_addr, {vec[i].addr[31:2], 2'b00});
        check($sformatf("v%0d_stall_acc", i), {31'h0, stall}, 32'h1);
        @(negedge clk); mem_ack = 1'b0; mem_rdata = 32'h5A5A_5A5A; #1;
        check($sformatf("v%0d_done", i), {31'h0, done}, 32'h1);
        check($sformatf("v%0d_stall_done", i), {31'h0, stall}, 32'h0);
        check($sformatf("v%0d_mreq_done", i), {31'h0, mem_req}, 32'h0);
      end else begin
        @(negedge clk); #1;
        check($sformatf("v%0d_adel", i), {31'h0, adel}, {31'h0, vec[i].fault == 2'd1});
        check($sformatf("v%0d_ades", i), {31'h0, ades}, {31'h0, vec[i].fault == 2'd2});
        check($sformatf("v%0d_mreq_flt", i), {31'h0, mem_req}, 32'h0);
        check($sformatf("v%0d_stall_flt", i), {31'h0, stall}, 32'h0);
      end
      check($sformatf("v%0d_rdata", i), rdata, vec[i].rdata);
      // req still held here; a re-issue would show up as mem_req next cycle
      @(negedge clk); req = 1'b0; #1;
      check($sformatf("v%0d_pulse_end", i), {29'h0, done, adel, ades}, 32'h0);
      check($sformatf("v%0d_mreq_after", i), {31'h0, mem_req}, 32'h0);
    end

    // Timeout: mem_req for exactly 15 cycles then a berr pulse.
    start_req(1'b0, 3'd0, 32'h1000_0010, 32'h0);
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk); #1;
      check($sformatf("to_mreq_c%0d", c), {30'h0, mem_req, berr}, 32'h2);
    end
    @(negedge clk); #1;
    check("to_berr", {29'h0, berr, mem_req, done}, 32'h4);
    check("to_stall", {31'h0, stall}, 32'h0);
    check("to_rdata", rdata, 32'h0000_007F);
    @(negedge clk); req = 1'b0; #1;
    check("to_berr_end", {30'h0, berr, mem_req}, 32'h0);

    // Ack on the 15th access cycle wins over the timeout.
    start_req(1'b0, 3'd0, 32'h1000_0014, 32'h0);
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk); #1;
    end
    @(negedge clk); mem_ack = 1'b1; mem_rdata = 32'hA5A5_0F0F; #1;
    check("late_mreq", {31'h0, mem_req}, 32'h1);
    @(negedge clk); mem_ack = 1'b0; #1;
    check("late_done", {30'h0, done, berr}, 32'h2);
    check("late_rdata", rdata, 32'hA5A5_0F0F);
    @(negedge clk); req = 1'b0; #1;

    // Stray ack in IDLE is ignored.
    @(negedge clk); mem_ack = 1'b1; mem_rdata = 32'h1111_1111; #1;
    @(negedge clk); mem_ack = 1'b0; #1;
    check("stray_ack", {29'h0, done, berr, mem_req}, 32'h0);
    check("stray_rdata", rdata, 32'hA5A5_0F0F);

    // Reset mid-access drops mem_req without a clock edge.
    start_req(1'b0, 3'd0, 32'h1000_0020, 32'h0);
    @(negedge clk); #1;
    check("rst_acc_mreq_before", {31'h0, mem_req}, 32'h1);
    rst_n = 1'b0; #1;
    check("rst_acc_mreq_async", {31'h0, mem_req}, 32'h0);
    check("rst_acc_be", {28'h0, mem_be}, 32'h0);
    check("rst_acc_stall_req", {31'h0, stall}, 32'h1);
    req = 1'b0;
    @(negedge clk); #1;
    check("rst_acc_flags", {30'h0, done, berr}, 32'h0);
    check("rst_acc_rdata", rdata, 32'h0);
    rst_n = 1'b1;
    start_req(1'b0, 3'd3, 32'h1000_0002, 32'h0);
    @(negedge clk); mem_ack = 1'b1; mem_rdata = 32'h8001_FFFF; #1;
    @(negedge clk); mem_ack = 1'b0; #1;
    check("post_rst_done", {31'h0, done}, 32'h1);
    check("post_rst_rdata", rdata, 32'h0000_8001);
    @(negedge clk); req = 1'b0; #1;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
